// File: rtl/fifo_wptr_ctrl_pkg.sv
// Shared async-FIFO helpers: default geometry and Gray/binary conversion,
// used by both the write-side and read-side pointer controllers.
package fifo_pkg;

  localparam int FIFO_ADDR_WIDTH = 4;
  localparam int FIFO_SYNC       = 2;

  // Conversion functions work on a fixed wide word; callers size-cast in and out.
  localparam int FIFO_FN_W = 32;

  function automatic logic [FIFO_FN_W-1:0] bin2gray(input logic [FIFO_FN_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix-XOR from the MSB down, done in log2 steps.
  function automatic logic [FIFO_FN_W-1:0] gray2bin(input logic [FIFO_FN_W-1:0] g);
    logic [FIFO_FN_W-1:0] b;
    b = g;
    for (int unsigned s = 1; s < FIFO_FN_W; s = s << 1) begin
      b = b ^ (b >> s);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_wptr_ctrl_if.sv
// Write-side bundle between the producer and the write pointer controller.
interface fifo_wptr_ctrl_if
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH = FIFO_ADDR_WIDTH
);
  logic                  wr_req_i;
  logic [ADDR_WIDTH:0]   rptr_gray_i;
  logic                  ovf_clr_i;
  logic                  wr_en_o;
  logic [ADDR_WIDTH-1:0] waddr_o;
  logic [ADDR_WIDTH:0]   wptr_gray_o;
  logic                  full_o;
  logic                  afull_o;
  logic [ADDR_WIDTH:0]   level_o;
  logic                  ovf_o;

  modport master (
    output wr_req_i, rptr_gray_i, ovf_clr_i,
    input  wr_en_o, waddr_o, wptr_gray_o, full_o, afull_o, level_o, ovf_o
  );

  modport slave (
    input  wr_req_i, rptr_gray_i, ovf_clr_i,
    output wr_en_o, waddr_o, wptr_gray_o, full_o, afull_o, level_o, ovf_o
  );
endinterface

// File: rtl/fifo_wptr_ctrl_sync.sv
// Multi-flop synchronizer for a Gray-coded bus; stage count derived from SYNC.
module sync #(
  parameter int DATA_WIDTH = 1,
  parameter int SYNC       = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] d_i,
  output logic [DATA_WIDTH-1:0] q_o
);
  localparam int C_SYNC = (SYNC == 0) ? 2 : (SYNC == 1) ? 3 : SYNC + 1;

  logic [DATA_WIDTH-1:0] stage_q [C_SYNC];

  // Shift chain: stage 0 samples the asynchronous input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < C_SYNC; i++) stage_q[i] <= '0;
    end else begin
      stage_q[0] <= d_i;
      for (int unsigned i = 1; i < C_SYNC; i++) stage_q[i] <= stage_q[i-1];
    end
  end

  assign q_o = stage_q[C_SYNC-1];
endmodule

// File: rtl/fifo_wptr_ctrl.sv
// Write-domain pointer and status controller for the asynchronous FIFO.
module fifo_wptr_ctrl
  import fifo_pkg::*;
#(
  parameter int ADDR_WIDTH  = FIFO_ADDR_WIDTH,
  parameter int SYNC        = FIFO_SYNC,
  parameter int AFULL_LEVEL = 12
) (
  input  logic             clk,
  input  logic             rst_n,
  fifo_wptr_ctrl_if.slave  bus
);
  localparam int AW    = ADDR_WIDTH;
  localparam int PTR_W = ADDR_WIDTH + 1;
  localparam logic [AW:0] AFULL_THR = PTR_W'(AFULL_LEVEL);

  logic [AW:0] wbin_q, wbin_d;
  logic [AW:0] wgray_q, wgray_d;
  logic [AW:0] level_q, level_d;
  logic [AW:0] rq, rbin;
  logic        full_q, full_d;
  logic        afull_q, afull_d;
  logic        ovf_q, ovf_d;
  logic        wr_en;

  sync #(
    .DATA_WIDTH (PTR_W),
    .SYNC       (SYNC)
  ) u_rptr_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .d_i   (bus.rptr_gray_i),
    .q_o   (rq)
  );

  assign wr_en = bus.wr_req_i & ~full_q;

  // Next pointer and status: the accepted write and the latest synced read
  // pointer are folded into one evaluation, so the flags track the write
  // at the same edge it is taken.
  always_comb begin
    wbin_d  = wbin_q + PTR_W'(wr_en);
    wgray_d = PTR_W'(bin2gray(FIFO_FN_W'(wbin_d)));
    rbin    = PTR_W'(gray2bin(FIFO_FN_W'(rq)));
    full_d  = (wgray_d == {~rq[AW:AW-1], rq[AW-2:0]});
    level_d = wbin_d - rbin;
    afull_d = (level_d >= AFULL_THR);
    ovf_d   = ovf_q;
    if (bus.wr_req_i && full_q) begin
      ovf_d = 1'b1;
    end else if (bus.ovf_clr_i) begin
      ovf_d = 1'b0;
    end
  end

  // Pointer and status registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wbin_q  <= '0;
      wgray_q <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
      afull_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      wbin_q  <= wbin_d;
      wgray_q <= wgray_d;
      level_q <= level_d;
      full_q  <= full_d;
      afull_q <= afull_d;
      ovf_q   <= ovf_d;
    end
  end

  assign bus.wr_en_o     = wr_en;
  assign bus.waddr_o     = wbin_q[AW-1:0];
  assign bus.wptr_gray_o = wgray_q;
  assign bus.full_o      = full_q;
  assign bus.afull_o     = afull_q;
  assign bus.level_o     = level_q;
  assign bus.ovf_o       = ovf_q;
endmodule

// File: tb/tb_fifo_wptr_ctrl.sv
// Bench for fifo_wptr_ctrl: occupancy-count reference model with a fixed
// read-pointer visibility delay, scenario tasks plus a randomized run.
module tb_fifo_wptr_ctrl;
  localparam int AW    = 4;
  localparam int DEPTH = 1 << AW;
  localparam int MODV  = 2 * DEPTH;
  localparam int LAG   = 3;       // synchronizer stages for SYNC=2
  localparam int AFULL = 12;
  localparam int VW    = AW + (AW + 1) + 1 + 1 + (AW + 1) + 1;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  fifo_wptr_ctrl_if #(.ADDR_WIDTH(AW)) bus ();

  fifo_wptr_ctrl #(
    .ADDR_WIDTH  (AW),
    .SYNC        (2),
    .AFULL_LEVEL (AFULL)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model: write count, visible read count, derived occupancy.
  int m_w, m_level;
  bit m_full, m_afull, m_ovf;
  int rhist[$];
  int rc;                     // read pointer currently driven (binary)
  bit obs_wr_en, exp_wr_en;
  logic [AW-1:0] obs_waddr;

  function automatic logic [VW-1:0] obs_vec();
    return {bus.waddr_o, bus.wptr_gray_o, bus.full_o, bus.afull_o, bus.level_o, bus.ovf_o};
  endfunction

  function automatic logic [VW-1:0] exp_vec();
    logic [AW-1:0] a;
    logic [AW:0]   g, l;
    a = AW'(m_w % DEPTH);
    g = (AW+1)'(m_w ^ (m_w >> 1));
    l = (AW+1)'(m_level);
    return {a, g, m_full, m_afull, l, m_ovf};
  endfunction

  task automatic model_reset();
    m_w = 0; m_level = 0; m_full = 0; m_afull = 0; m_ovf = 0; rc = 0;
    rhist.delete();
    for (int i = 0; i < LAG; i++) rhist.push_back(0);
  endtask

  // One clock: drive inputs at negedge, sample combinational outputs, advance model.
  task automatic step(input bit req, input bit clr);
    int r_seen;
    @(negedge clk);
    bus.wr_req_i    = req;
    bus.rptr_gray_i = (AW+1)'(rc ^ (rc >> 1));
    bus.ovf_clr_i   = clr;
    #1;
    obs_wr_en = bus.wr_en_o;
    obs_waddr = bus.waddr_o;
    exp_wr_en = req && !m_full;
    @(posedge clk);
    r_seen = rhist.pop_front();
    rhist.push_back(rc);
    if (req && m_full) m_ovf = 1;
    else if (clr)      m_ovf = 0;
    if (exp_wr_en) m_w = (m_w + 1) % MODV;
    m_level = (m_w - r_seen + MODV) % MODV;
    m_full  = (m_level == DEPTH);
    m_afull = (m_level >= AFULL);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.wr_req_i = 0; bus.rptr_gray_i = '0; bus.ovf_clr_i = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    if (obs_vec() !== '0 || bus.wr_en_o !== 1'b0) begin
      $display("FAIL reset_state: got %h wr_en %b, want 0", obs_vec(), bus.wr_en_o); errors++;
    end
    checks++;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_fill();
    for (int i = 1; i <= DEPTH; i++) begin
      step(1, 0);
      if (obs_wr_en !== exp_wr_en) begin
        $display("FAIL fill_wr_en[%0d]: got %b want %b", i, obs_wr_en, exp_wr_en); errors++;
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL fill_state[%0d]: got %h want %h", i, obs_vec(), exp_vec()); errors++;
      end
      checks++;
      if (i == AFULL - 1 || i == AFULL) begin
        if (bus.afull_o !== (i == AFULL)) begin
          $display("FAIL fill_afull_edge[%0d]: got %b want %b", i, bus.afull_o, i == AFULL); errors++;
        end
        checks++;
      end
      if (bus.full_o !== (i == DEPTH)) begin
        $display("FAIL fill_full_edge[%0d]: got %b want %b", i, bus.full_o, i == DEPTH); errors++;
      end
      checks++;
    end
    if (bus.level_o !== 5'd16 || bus.waddr_o !== 4'd0 || bus.wptr_gray_o !== 5'b11000) begin
      $display("FAIL fill_final: got level %0d waddr %0d gray %b, want 16 0 11000",
               bus.level_o, bus.waddr_o, bus.wptr_gray_o); errors++;
    end
    checks++;
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 3; i++) begin
      step(1, 0);
      if (obs_wr_en !== 1'b0 || bus.waddr_o !== 4'd0 || bus.ovf_o !== 1'b1) begin
        $display("FAIL ovf_refuse[%0d]: got wr_en %b waddr %0d ovf %b, want 0 0 1",
                 i, obs_wr_en, bus.waddr_o, bus.ovf_o); errors++;
      end
      checks++;
    end
    step(1, 1);
    if (bus.ovf_o !== 1'b1) begin
      $display("FAIL ovf_set_wins: got %b want 1", bus.ovf_o); errors++;
    end
    checks++;
    step(0, 1);
    if (bus.ovf_o !== 1'b0 || obs_vec() !== exp_vec()) begin
      $display("FAIL ovf_clear: got ovf %b state %h want 0 %h", bus.ovf_o, obs_vec(), exp_vec()); errors++;
    end
    checks++;
  endtask

  task automatic test_read_release();
    rc = 4;
    for (int i = 1; i <= 4; i++) begin
      step(0, 0);
      if (bus.full_o !== (i < 4)) begin
        $display("FAIL release_full[%0d]: got %b want %b", i, bus.full_o, i < 4); errors++;
      end
      checks++;
    end
    if (bus.level_o !== 5'd12 || bus.afull_o !== 1'b1) begin
      $display("FAIL release_level: got %0d afull %b want 12 1", bus.level_o, bus.afull_o); errors++;
    end
    checks++;
    step(1, 0);
    if (obs_wr_en !== 1'b1 || obs_waddr !== 4'd0) begin
      $display("FAIL release_write: got wr_en %b waddr %0d want 1 0", obs_wr_en, obs_waddr); errors++;
    end
    checks++;
    if (obs_vec() !== exp_vec()) begin
      $display("FAIL release_state: got %h want %h", obs_vec(), exp_vec()); errors++;
    end
    checks++;
  endtask

  task automatic test_wrap();
    int wraps = 0;
    logic [AW:0] g_prev;
    logic [AW-1:0] a_prev;
    rc = (m_w - 2 + MODV) % MODV;
    repeat (LAG + 1) step(0, 0);
    for (int i = 0; i < 40; i++) begin
      g_prev = bus.wptr_gray_o;
      a_prev = bus.waddr_o;
      rc = (m_w - 2 + MODV) % MODV;
      step(1, 0);
      if (a_prev == 4'd15 && bus.waddr_o == 4'd0) wraps++;
      if ($countones(g_prev ^ bus.wptr_gray_o) != 1 || bus.full_o !== 1'b0) begin
        $display("FAIL wrap_step[%0d]: gray %b->%b full %b, want 1-bit change and full 0",
                 i, g_prev, bus.wptr_gray_o, bus.full_o); errors++;
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL wrap_state[%0d]: got %h want %h", i, obs_vec(), exp_vec()); errors++;
      end
      checks++;
    end
    if (wraps != 2) begin
      $display("FAIL wrap_count: got %0d want 2", wraps); errors++;
    end
    checks++;
  endtask

  task automatic test_simultaneous();
    int guard = 0;
    repeat (LAG + 1) step(0, 0);
    while (m_level < DEPTH - 1 && guard < 32) begin
      step(1, 0);
      guard++;
    end
    if (bus.level_o !== 5'(DEPTH - 1)) begin
      $display("FAIL simul_setup: got level %0d want 15", bus.level_o); errors++;
    end
    checks++;
    rc = (rc + 1) % MODV;
    repeat (LAG) step(0, 0);
    step(1, 0);
    if (obs_wr_en !== 1'b1 || bus.level_o !== 5'd15 || bus.full_o !== 1'b0) begin
      $display("FAIL simul_wr_rd: got wr_en %b level %0d full %b want 1 15 0",
               obs_wr_en, bus.level_o, bus.full_o); errors++;
    end
    checks++;
  endtask

  task automatic test_reset_mid();
    step(1, 0);            // level 16
    step(1, 0);            // refused, sets overflow
    rc = (rc + 7) % MODV;
    repeat (LAG + 1) step(0, 0);
    if (bus.level_o !== 5'd9 || bus.ovf_o !== 1'b1) begin
      $display("FAIL rstmid_setup: got level %0d ovf %b want 9 1", bus.level_o, bus.ovf_o); errors++;
    end
    checks++;
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    if (obs_vec() !== '0) begin
      $display("FAIL rstmid_async: got %h want 0", obs_vec()); errors++;
    end
    checks++;
    bus.wr_req_i = 0; bus.rptr_gray_i = '0; bus.ovf_clr_i = 0;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk); rst_n = 1'b1;
    step(1, 0);
    if (obs_wr_en !== 1'b1 || obs_waddr !== 4'd0 || obs_vec() !== exp_vec()) begin
      $display("FAIL rstmid_first_write: got wr_en %b waddr %0d state %h want 1 0 %h",
               obs_wr_en, obs_waddr, obs_vec(), exp_vec()); errors++;
    end
    checks++;
  endtask

  task automatic test_random();
    int occ;
    for (int i = 0; i < 400; i++) begin
      occ = (m_w - rc + MODV) % MODV;
      if (occ > 0 && $urandom_range(9, 0) < 4) rc = (rc + 1) % MODV;
      step($urandom_range(9, 0) < 7, $urandom_range(15, 0) == 0);
      if (obs_wr_en !== exp_wr_en) begin
        $display("FAIL rand_wr_en[%0d]: got %b want %b", i, obs_wr_en, exp_wr_en); errors++;
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        $display("FAIL rand_state[%0d]: got %h want %h", i, obs_vec(), exp_vec()); errors++;
      end
      checks++;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_fill();
    test_overflow();
    test_read_release();
    test_wrap();
    test_simultaneous();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
